// File: rtl/three_to_one_mux.sv
// three_to_one_mux: 3:1 data selector with a combinational result and a registered
// result carrying valid and illegal-select flags.
module three_to_one_mux #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [1:0]       sel,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out_comb,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             sel_err
);
    // sel = 11 yields a defined zero rather than X or a hold
    always_comb out_comb = sel == 2'b00 ? a : sel == 2'b01 ? b : sel == 2'b10 ? c : '0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            out_valid <= 1'b0;
            sel_err   <= 1'b0;
        end else begin
            if (in_valid) out <= out_comb;
            out_valid <= in_valid;
            sel_err   <= in_valid && sel == 2'b11;
        end
    end
endmodule

// File: tb/tb_three_to_one_mux.sv
// tb_three_to_one_mux: scoreboard bench for the 32-bit and 8-bit selector instances.
module tb_three_to_one_mux;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic        rst_n, in_valid;
    logic [1:0]  sel;
    logic [31:0] a, b, c, out_comb, out;
    logic        out_valid, sel_err;
    logic [7:0]  a8, b8, c8, out_comb8, out8;
    logic        out_valid8, sel_err8;
    three_to_one_mux dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .sel(sel), .in_valid(in_valid),
        .out_comb(out_comb), .out(out), .out_valid(out_valid), .sel_err(sel_err)
    );
    three_to_one_mux #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .c(c8), .sel(sel), .in_valid(in_valid),
        .out_comb(out_comb8), .out(out8), .out_valid(out_valid8), .sel_err(sel_err8)
    );
    int pass_cnt = 0;
    int total = 0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask
    function automatic logic [31:0] pick(input logic [31:0] x, y, z, input logic [1:0] s);
        case (s)
            2'd0: return x;
            2'd1: return y;
            2'd2: return z;
            default: return 32'h0;
        endcase
    endfunction
    typedef struct {
        logic [31:0] o;
        logic        v;
        logic        e;
        logic [7:0]  o8;
    } exp_t;
    exp_t sb[$];
    logic [31:0] m_out = '0;
    logic [7:0]  m_out8 = '0;
    // Check comb outputs now, push the registered expectation, pop it after the edge.
    task automatic step(input string tag);
        exp_t x;
        logic [31:0] p8;
        #1;
        p8 = pick({24'h0, a8}, {24'h0, b8}, {24'h0, c8}, sel);
        check({tag, "_comb"}, out_comb, pick(a, b, c, sel));
        check({tag, "_comb8"}, {24'h0, out_comb8}, p8);
        if (in_valid) begin
            m_out  = pick(a, b, c, sel);
            m_out8 = p8[7:0];
        end
        x.o = m_out; x.v = in_valid; x.e = in_valid && sel == 2'b11; x.o8 = m_out8;
        sb.push_back(x);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        check({tag, "_out"}, out, x.o);
        check({tag, "_valid"}, {31'h0, out_valid}, {31'h0, x.v});
        check({tag, "_err"}, {31'h0, sel_err}, {31'h0, x.e});
        check({tag, "_out8"}, {24'h0, out8}, {24'h0, x.o8});
    endtask
    task automatic pulse_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        check({tag, "_out"}, out, 32'h0);
        check({tag, "_valid"}, {31'h0, out_valid}, 32'h0);
        check({tag, "_err"}, {31'h0, sel_err}, 32'h0);
        check({tag, "_comb"}, out_comb, pick(a, b, c, sel));
        m_out  = '0;
        m_out8 = '0;
        #2 rst_n = 1'b1;
    endtask
    initial begin
        rst_n = 1'b0; in_valid = 1'b0; sel = 2'b00;
        a = 32'h1; b = 32'h2; c = 32'h3; a8 = 8'hFF; b8 = 8'h5A; c8 = 8'hA5;
        #12;
        check("rst_out", out, 32'h0);
        check("rst_valid", {31'h0, out_valid}, 32'h0);
        check("rst_err", {31'h0, sel_err}, 32'h0);
        rst_n = 1'b1;
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            #1;
            check("sweep_comb", out_comb, s == 3 ? 32'h0 : 32'(s + 1));
            #9;
        end
        in_valid = 1'b1;
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            step("reg");
        end
        sel = 2'b01;
        step("cap_b");
        in_valid = 1'b0; sel = 2'b10; c = 32'hDEAD;
        step("hold");
        check("hold_val", out, 32'h2);
        in_valid = 1'b1; sel = 2'b00; a = 32'h5;
        step("preload");
        pulse_reset("async_rst");
        for (int i = 0; i < 6; i++) begin
            sel = 2'(i % 3);
            a = 32'h100 + i; b = 32'h200 + i; c = 32'h300 + i;
            step("stream");
            if (i == 2) pulse_reset("mid_rst");
        end
        for (int i = 0; i < 12; i++) begin
            a = $urandom; b = $urandom; c = $urandom;
            a8 = 8'($urandom); b8 = 8'($urandom); c8 = 8'($urandom);
            sel = 2'($urandom_range(0, 3));
            in_valid = 1'($urandom_range(0, 1));
            step("rand");
        end
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
